reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter LOCK_FILTER, default 16, meaning consecutive synchronized pll_lock-high cycles required before lock is accepted (range 1..65535).
REQ-002 SHALL have parameter HOLD_CYCLES, default 1024, meaning cycles both resets stay asserted after lock is accepted (range 1..65535).
REQ-003 SHALL have parameter STAGGER_CYCLES, default 64, meaning cycles between rst_sdram release and rst_core release (range 1..65535).
REQ-004 SHALL have port clock  input  1  PLL output clock, sole clock domain.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port pll_lock  input  1  PLL lock indicator, asynchronous to clock.
REQ-007 SHALL have port soft_reset_req  input  1  single-cycle request to re-run the hold/stagger sequence.
REQ-008 SHALL have port rst_sdram  output  1  active-high reset for the memory controller.
REQ-009 SHALL have port rst_core  output  1  active-high reset for the CPU core.
REQ-010 SHALL have port ready  output  1  high only in RUN.
REQ-011 SHALL have port state  output  2  current state encoding.
REQ-012 SHALL have port lock_lost_count  output  8  saturating count of lock losses occurring in RUN.

Function
REQ-013 SHALL pass pll_lock through a two-flop synchronizer; only the second flop (lock_s) is used downstream.
REQ-014 SHALL keep a 16-bit filter counter: +1 on each edge with lock_s=1, saturating at LOCK_FILTER; cleared on any edge with lock_s=0.
REQ-015 SHALL register locked_f = (filter counter == LOCK_FILTER); a single lock_s=0 cycle clears it on the following edge.
REQ-016 SHALL implement states WAIT_LOCK=0, HOLD=1, STAGGER=2, RUN=3, driven on port state.
REQ-017 WAIT_LOCK: rst_sdram=1, rst_core=1, ready=0; go to HOLD on an edge where locked_f=1, clearing the 16-bit phase counter.
REQ-018 HOLD: both resets=1; remain exactly HOLD_CYCLES cycles, then STAGGER with rst_sdram=0 from the transition edge.
REQ-019 STAGGER: rst_sdram=0, rst_core=1; remain exactly STAGGER_CYCLES cycles, then RUN with rst_core=0 and ready=1 from the transition edge.
REQ-020 RUN: rst_sdram=0, rst_core=0, ready=1; hold until lock loss or soft_reset_req.
REQ-021 Lock loss (locked_f=0 in HOLD, STAGGER or RUN) SHALL go to WAIT_LOCK, asserting both resets and clearing ready on that edge.
REQ-022 Lock loss from RUN SHALL increment lock_lost_count by 1, saturating at 255; lock loss from other states SHALL not count.
REQ-023 soft_reset_req=1 in STAGGER or RUN SHALL go to HOLD with both resets asserted and the phase counter cleared; in HOLD it SHALL restart the HOLD count; in WAIT_LOCK it SHALL be ignored.
REQ-024 When lock loss and soft_reset_req coincide, lock loss SHALL win (WAIT_LOCK, count rule of REQ-022).
REQ-025 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-026 Timing, E0 = first edge sampling pll_lock=1 with lock steady afterwards: rst_sdram falls after edge E(2+LOCK_FILTER+HOLD_CYCLES); rst_core and ready change after edge E(2+LOCK_FILTER+HOLD_CYCLES+STAGGER_CYCLES).
REQ-027 Timing, Ek = edge sampling pll_lock=0 while locked: both resets assert and ready falls after edge E(k+3).

Reset
REQ-028 reset=1 at an edge SHALL set state=WAIT_LOCK, rst_sdram=1, rst_core=1, ready=0, lock_lost_count=0, synchronizer flops=0, filter and phase counters=0.
REQ-029 reset SHALL take priority over all other inputs, including mid-sequence; after release, the sequence restarts from WAIT_LOCK per REQ-026.

Verification (LOCK_FILTER=4, HOLD_CYCLES=8, STAGGER_CYCLES=4)
REQ-030 Power-up: reset 3 cycles, pll_lock high at E0 -> rst_sdram falls after E14, rst_core falls and ready rises after E18, state=3.
REQ-031 Lock glitch: pll_lock high, low for 1 cycle at E2, then high -> filter restarts, rst_sdram falls after E(glitch-end + 14 offset) with no early release; lock_lost_count stays 0.
REQ-032 Lock loss in RUN: pll_lock low at Ek -> resets=1, ready=0 after E(k+3); lock_lost_count=1; relock repeats REQ-030 timing.
REQ-033 Saturation: 260 RUN lock losses -> lock_lost_count=255, no wrap.
REQ-034 soft_reset_req in RUN at En -> both resets=1 after En; rst_sdram falls after E(n+8), rst_core after E(n+12); simultaneous soft_reset_req and lock loss -> WAIT_LOCK, count+1.
REQ-035 reset asserted in STAGGER -> next edge all outputs at reset values; sequence restarts.

Source files
------------

// File: rtl/reset_sequencer.sv
// ============================================================================
// Module      : reset_sequencer
// Description : PLL-lock-qualified staged reset release (SDRAM, then core).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_sequencer #(
    parameter int LOCK_FILTER    = 16,
    parameter int HOLD_CYCLES    = 1024,
    parameter int STAGGER_CYCLES = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       soft_reset_req,
    output logic       rst_sdram,
    output logic       rst_core,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] lock_lost_count
);

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] HOLD      = 2'd1;
    localparam logic [1:0] STAGGER   = 2'd2;
    localparam logic [1:0] RUN       = 2'd3;

    localparam logic [15:0] LOCK_MAX     = 16'(LOCK_FILTER);
    localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] STAGGER_LAST = 16'(STAGGER_CYCLES - 1);

    logic        sync_meta;
    logic        lock_s;
    logic [15:0] filter_cnt;
    logic [15:0] filter_next;
    logic        locked_f;
    logic [15:0] phase_cnt;
    logic [15:0] phase_next;
    logic [1:0]  state_next;
    logic [7:0]  count_next;

    always_comb begin
        filter_next = 16'd0;
        if (lock_s) begin
            filter_next = (filter_cnt == LOCK_MAX) ? filter_cnt : filter_cnt + 16'd1;
        end
    end

    // Loss handling is checked first in every locked state so it beats soft_reset_req.
    always_comb begin
        state_next = state;
        phase_next = phase_cnt;
        count_next = lock_lost_count;
        case (state)
            WAIT_LOCK: begin
                if (locked_f) begin
                    state_next = HOLD;
                    phase_next = 16'd0;
                end
            end
            HOLD: begin
                if (!locked_f) begin
                    state_next = WAIT_LOCK;
                end else if (soft_reset_req) begin
                    phase_next = 16'd0;
                end else if (phase_cnt == HOLD_LAST) begin
                    state_next = STAGGER;
                    phase_next = 16'd0;
                end else begin
                    phase_next = phase_cnt + 16'd1;
                end
            end
            STAGGER: begin
                if (!locked_f) begin
                    state_next = WAIT_LOCK;
                end else if (soft_reset_req) begin
                    state_next = HOLD;
                    phase_next = 16'd0;
                end else if (phase_cnt == STAGGER_LAST) begin
                    state_next = RUN;
                    phase_next = 16'd0;
                end else begin
                    phase_next = phase_cnt + 16'd1;
                end
            end
            RUN: begin
                if (!locked_f) begin
                    state_next = WAIT_LOCK;
                    if (lock_lost_count != 8'hFF) begin
                        count_next = lock_lost_count + 8'd1;
                    end
                end else if (soft_reset_req) begin
                    state_next = HOLD;
                    phase_next = 16'd0;
                end
            end
            default: begin
                state_next = WAIT_LOCK;
                phase_next = 16'd0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the transition edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta       <= 1'b0;
            lock_s          <= 1'b0;
            filter_cnt      <= 16'd0;
            locked_f        <= 1'b0;
            phase_cnt       <= 16'd0;
            state           <= WAIT_LOCK;
            lock_lost_count <= 8'd0;
            rst_sdram       <= 1'b1;
            rst_core        <= 1'b1;
            ready           <= 1'b0;
        end else begin
            sync_meta       <= pll_lock;
            lock_s          <= sync_meta;
            filter_cnt      <= filter_next;
            locked_f        <= (filter_next == LOCK_MAX);
            phase_cnt       <= phase_next;
            state           <= state_next;
            lock_lost_count <= count_next;
            rst_sdram       <= (state_next == WAIT_LOCK) || (state_next == HOLD);
            rst_core        <= (state_next != RUN);
            ready           <= (state_next == RUN);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Scoreboard bench for reset_sequencer (LF=4, HOLD=8, STAGGER=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_STAG = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    logic       clock = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       soft_reset_req;
    logic       rst_sdram;
    logic       rst_core;
    logic       ready;
    logic [1:0] state;
    logic [7:0] lock_lost_count;

    reset_sequencer #(
        .LOCK_FILTER   (4),
        .HOLD_CYCLES   (8),
        .STAGGER_CYCLES(4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .pll_lock       (pll_lock),
        .soft_reset_req (soft_reset_req),
        .rst_sdram      (rst_sdram),
        .rst_core       (rst_core),
        .ready          (ready),
        .state          (state),
        .lock_lost_count(lock_lost_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [12:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int at, input string tag, input logic [1:0] st,
                        input logic sd, input logic co, input logic rd, input int cnt);
        exp_t e;
        e.at  = at;
        e.exp = {st, sd, co, rd, 8'(cnt)};
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Outputs are compared on the falling edge after the edge each entry names.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check(e.tag, {state, rst_sdram, rst_core, ready, lock_lost_count}, e.exp);
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic relock_checks(input int e0, input int cnt);
        push(e0 + 13, "hold_end",    S_HOLD, 1'b1, 1'b1, 1'b0, cnt);
        push(e0 + 14, "sdram_rel",   S_STAG, 1'b0, 1'b1, 1'b0, cnt);
        push(e0 + 17, "stagger_end", S_STAG, 1'b0, 1'b1, 1'b0, cnt);
        push(e0 + 18, "core_rel",    S_RUN,  1'b0, 1'b0, 1'b1, cnt);
    endtask

    // One-cycle lock drop from RUN, then steady relock.
    task automatic lose_lock();
        int k;
        int e0;
        k = cyc + 1;
        pll_lock = 1'b0;
        push(k + 2, "loss_pre", S_RUN, 1'b0, 1'b0, 1'b1, exp_cnt);
        if (exp_cnt < 255) exp_cnt++;
        push(k + 3, "loss", S_WAIT, 1'b1, 1'b1, 1'b0, exp_cnt);
        @(negedge clock);
        pll_lock = 1'b1;
        e0 = k + 1;
        relock_checks(e0, exp_cnt);
        wait_until(e0 + 18);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int n;
        int k;
        reset          = 1'b1;
        pll_lock       = 1'b0;
        soft_reset_req = 1'b0;

        // Power-up
        push(1, "reset_e1", S_WAIT, 1'b1, 1'b1, 1'b0, 0);
        push(3, "reset_e3", S_WAIT, 1'b1, 1'b1, 1'b0, 0);
        wait_until(3);
        reset    = 1'b0;
        pll_lock = 1'b1;
        e0       = cyc + 1;
        push(e0 + 5, "pre_hold", S_WAIT, 1'b1, 1'b1, 1'b0, 0);
        push(e0 + 6, "hold_in",  S_HOLD, 1'b1, 1'b1, 1'b0, 0);
        relock_checks(e0, 0);
        wait_until(e0 + 18);

        // Lock loss in RUN
        lose_lock();

        // Soft reset in RUN
        n = cyc + 1;
        soft_reset_req = 1'b1;
        push(n,      "soft_hold", S_HOLD, 1'b1, 1'b1, 1'b0, exp_cnt);
        push(n + 7,  "soft_h7",   S_HOLD, 1'b1, 1'b1, 1'b0, exp_cnt);
        push(n + 8,  "soft_sd",   S_STAG, 1'b0, 1'b1, 1'b0, exp_cnt);
        push(n + 11, "soft_s11",  S_STAG, 1'b0, 1'b1, 1'b0, exp_cnt);
        push(n + 12, "soft_run",  S_RUN,  1'b0, 1'b0, 1'b1, exp_cnt);
        @(negedge clock);
        soft_reset_req = 1'b0;
        wait_until(n + 12);

        // Soft reset while in HOLD restarts the hold count
        n = cyc + 1;
        soft_reset_req = 1'b1;
        @(negedge clock);
        soft_reset_req = 1'b0;
        wait_until(n + 4);
        soft_reset_req = 1'b1;
        push(n + 12, "rehold_h",   S_HOLD, 1'b1, 1'b1, 1'b0, exp_cnt);
        push(n + 13, "rehold_sd",  S_STAG, 1'b0, 1'b1, 1'b0, exp_cnt);
        push(n + 16, "rehold_s",   S_STAG, 1'b0, 1'b1, 1'b0, exp_cnt);
        push(n + 17, "rehold_run", S_RUN,  1'b0, 1'b0, 1'b1, exp_cnt);
        @(negedge clock);
        soft_reset_req = 1'b0;
        wait_until(n + 17);

        // Soft reset coinciding with lock loss
        k = cyc + 1;
        pll_lock = 1'b0;
        push(k + 2, "coin_pre", S_RUN, 1'b0, 1'b0, 1'b1, exp_cnt);
        exp_cnt++;
        push(k + 3, "coin_loss", S_WAIT, 1'b1, 1'b1, 1'b0, exp_cnt);
        push(k + 4, "coin_wait", S_WAIT, 1'b1, 1'b1, 1'b0, exp_cnt);
        relock_checks(k + 1, exp_cnt);
        @(negedge clock);
        pll_lock = 1'b1;
        wait_until(k + 2);
        soft_reset_req = 1'b1;
        @(negedge clock);
        soft_reset_req = 1'b0;
        wait_until(k + 19);

        // Reset asserted during STAGGER
        n = cyc + 1;
        soft_reset_req = 1'b1;
        @(negedge clock);
        soft_reset_req = 1'b0;
        wait_until(n + 8);
        reset   = 1'b1;
        exp_cnt = 0;
        push(n + 9, "rst_stag", S_WAIT, 1'b1, 1'b1, 1'b0, 0);
        @(negedge clock);
        reset = 1'b0;
        e0    = cyc + 1;
        relock_checks(e0, 0);
        wait_until(e0 + 18);

        // Lock glitch before acceptance
        reset    = 1'b1;
        pll_lock = 1'b0;
        @(negedge clock);
        reset    = 1'b0;
        pll_lock = 1'b1;
        e0       = cyc + 1;
        wait_until(e0 + 1);
        pll_lock = 1'b0;
        @(negedge clock);
        pll_lock = 1'b1;
        push(e0 + 8,  "glitch_wait",  S_WAIT, 1'b1, 1'b1, 1'b0, 0);
        push(e0 + 14, "glitch_early", S_HOLD, 1'b1, 1'b1, 1'b0, 0);
        relock_checks(e0 + 3, 0);
        wait_until(e0 + 21);

        // Saturation of the lock-loss counter
        for (int i = 0; i < 260; i++) begin
            lose_lock();
        end

        wait_until(cyc + 2);
        check("sb_drain", 13'(sb.size()), 13'd0);
        check("sat_count", {5'd0, lock_lost_count}, 13'd255);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
